// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - dual AD7643 conversion sequencer and serial reader
// Periodic ADCLK start, busy wait with timeout, 18-bit shift-in, 16-bit valid/ready output.
module adc_serial_reader #(
  parameter int SCLK_DIV     = 1,
  parameter int PERIOD       = 100,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        CLR,
  input  logic        BUSYAD0,
  input  logic        BUSYAD1,
  input  logic        SDOUT0,
  input  logic        SDOUT1,
  output logic        ADCLK,
  output logic        SCLK,
  output logic        CS,
  output logic [15:0] DA,
  output logic [15:0] DB,
  output logic        DVALID,
  input  logic        DREADY,
  output logic        OVF,
  output logic        ERR,
  output logic [15:0] SCNT
);

  localparam int PER_W = $clog2(PERIOD);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam int DIV_W = $clog2(SCLK_DIV + 1);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_WAITB, S_SHIFT, S_STORE, S_HOLD
  } state_t;

  state_t             r_state;
  logic               r_adclk;
  logic               r_sclk;
  logic [15:0]        r_da;
  logic [15:0]        r_db;
  logic               r_dvalid;
  logic               r_ovf;
  logic               r_err;
  logic [15:0]        r_scnt;
  logic [17:0]        r_sh0;
  logic [17:0]        r_sh1;
  logic [PER_W-1:0]   r_period_cnt;
  logic [TO_W-1:0]    r_wait_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [4:0]         r_bit_cnt;
  logic               r_conv_cnt;
  logic [1:0]         r_busy_s1;
  logic [1:0]         r_busy_s2;
  logic               r_busy_seen;

  logic w_xfer;
  logic w_busy_any;
  logic w_period_done;

  assign w_xfer        = r_dvalid & DREADY;
  assign w_busy_any    = |r_busy_s2;
  assign w_period_done = (r_period_cnt == PER_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_adclk      <= 1'b1;
      r_sclk       <= 1'b0;
      r_da         <= '0;
      r_db         <= '0;
      r_dvalid     <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_scnt       <= '0;
      r_sh0        <= '0;
      r_sh1        <= '0;
      r_period_cnt <= '0;
      r_wait_cnt   <= '0;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_conv_cnt   <= 1'b0;
      r_busy_s1    <= '0;
      r_busy_s2    <= '0;
      r_busy_seen  <= 1'b0;
    end else begin
      // BUSY comes from the converter's own timing domain
      r_busy_s1 <= {BUSYAD1, BUSYAD0};
      r_busy_s2 <= r_busy_s1;

      // Saturates so a late HOLD entry still releases immediately
      if (!w_period_done)
        r_period_cnt <= r_period_cnt + PER_ONE;

      if (w_xfer)
        r_dvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (EN) begin
            r_state      <= S_CONV;
            r_adclk      <= 1'b0;
            r_conv_cnt   <= 1'b0;
            r_period_cnt <= '0;
          end
        end
        S_CONV: begin
          if (r_conv_cnt) begin
            r_state     <= S_WAITB;
            r_adclk     <= 1'b1;
            r_wait_cnt  <= '0;
            r_busy_seen <= 1'b0;
          end else begin
            r_conv_cnt <= 1'b1;
          end
        end
        S_WAITB: begin
          if (r_busy_seen && !w_busy_any) begin
            r_state   <= S_SHIFT;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
          end else if (r_wait_cnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_ONE;
            if (w_busy_any)
              r_busy_seen <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
            if (!r_sclk) begin
              r_sh0 <= {r_sh0[16:0], SDOUT0};
              r_sh1 <= {r_sh1[16:0], SDOUT1};
            end else if (r_bit_cnt == 5'd17) begin
              r_state <= S_STORE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
          end
        end
        S_STORE: begin
          r_scnt  <= r_scnt + 16'd1;
          r_state <= S_HOLD;
          // A pending word being accepted this edge frees the slot for the new one
          if (!r_dvalid || DREADY) begin
            r_da     <= r_sh0[17:2];
            r_db     <= r_sh1[17:2];
            r_dvalid <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_period_done) begin
            if (EN) begin
              r_state      <= S_CONV;
              r_adclk      <= 1'b0;
              r_conv_cnt   <= 1'b0;
              r_period_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (CLR) begin
        r_ovf  <= 1'b0;
        r_err  <= 1'b0;
        r_scnt <= '0;
      end
    end
  end

  assign ADCLK  = r_adclk;
  assign SCLK   = r_sclk;
  assign CS     = 1'b0;
  assign DA     = r_da;
  assign DB     = r_db;
  assign DVALID = r_dvalid;
  assign OVF    = r_ovf;
  assign ERR    = r_err;
  assign SCNT   = r_scnt;

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb/tb_adc_serial_reader.sv - scoreboard bench for adc_serial_reader
// Behavioural AD7643 pair pushes expected samples; a monitor pops them on each transfer.
module tb_adc_serial_reader;

  localparam int PER = 100;

  logic        CLK = 1'b0;
  logic        RST, EN, CLR, BUSYAD0, BUSYAD1, SDOUT0, SDOUT1, DREADY;
  logic        ADCLK, SCLK, CS, DVALID, OVF, ERR;
  logic [15:0] DA, DB, SCNT;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          sclk_cnt = 0;
  int          dv_cycles = 0;
  int          bit_idx = 18;
  int          falls[$];
  logic [31:0] sb[$];
  logic [17:0] w0 = '0, w1 = '0, next_w0 = '0, next_w1 = '0;
  logic        busy_stuck = 1'b0;

  adc_serial_reader #(.SCLK_DIV(1), .PERIOD(PER), .BUSY_TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR),
    .BUSYAD0(BUSYAD0), .BUSYAD1(BUSYAD1), .SDOUT0(SDOUT0), .SDOUT1(SDOUT1),
    .ADCLK(ADCLK), .SCLK(SCLK), .CS(CS),
    .DA(DA), .DB(DB), .DVALID(DVALID), .DREADY(DREADY),
    .OVF(OVF), .ERR(ERR), .SCNT(SCNT)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end
  initial forever begin @(posedge SCLK); sclk_cnt++; end
  initial forever begin @(negedge SCLK); bit_idx++; end

  assign SDOUT0 = (bit_idx < 18) ? w0[17 - bit_idx] : 1'b0;
  assign SDOUT1 = (bit_idx < 18) ? w1[17 - bit_idx] : 1'b0;

  // Converter model: latch the next word pair at each conversion start
  initial begin
    BUSYAD0 = 1'b0;
    BUSYAD1 = 1'b0;
    forever begin
      @(negedge ADCLK);
      falls.push_back(cyc);
      w0 = next_w0;
      w1 = next_w1;
      bit_idx = 0;
      sb.push_back({next_w0[17:2], next_w1[17:2]});
      next_w0 = 18'($urandom);
      next_w1 = 18'($urandom);
      if (!busy_stuck) begin
        repeat (2) @(posedge CLK);
        #1 BUSYAD0 = 1'b1; BUSYAD1 = 1'b1;
        repeat (6) @(posedge CLK);
        #1 BUSYAD0 = 1'b0; BUSYAD1 = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic [31:0] exp_v;
    forever begin
      @(negedge CLK);
      if (DVALID === 1'b1) begin
        dv_cycles++;
        if (DREADY === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL xfer_unexpected: got DA=%h DB=%h, required no transfer", DA, DB);
          end else begin
            exp_v = sb.pop_front();
            if ({DA, DB} !== exp_v) begin
              bad++;
              $display("FAIL xfer_data: got DA=%h DB=%h, required DA=%h DB=%h",
                       DA, DB, exp_v[31:16], exp_v[15:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; DREADY = 1'b1; busy_stuck = 1'b0;
    step(3);
    RST = 1'b0;
    sb.delete(); falls.delete();
    sclk_cnt = 0; dv_cycles = 0;
  endtask

  task automatic pulse_en();
    step(1); EN = 1'b1;
    step(1); EN = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; DREADY = 1'b1;
    #3;
    total++;
    if ({ADCLK, SCLK, CS, DVALID, OVF, ERR} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctrl: got ADCLK,SCLK,CS,DVALID,OVF,ERR=%b, required 100000",
               {ADCLK, SCLK, CS, DVALID, OVF, ERR});
    end
    total++;
    if ({DA, DB, SCNT} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data: got DA=%h DB=%h SCNT=%h, required all 0", DA, DB, SCNT);
    end
    do_reset();
    step(10);
    total++;
    if (ADCLK !== 1'b1 || falls.size() != 0) begin
      bad++;
      $display("FAIL idle_no_conv: got ADCLK=%b falls=%0d, required 1 and 0", ADCLK, falls.size());
    end
  endtask

  task automatic test_single();
    do_reset();
    next_w0 = 18'h2AAAA;
    next_w1 = 18'h3FFFF;
    pulse_en();
    step(PER + 20);
    total++;
    if ({DA, DB} !== 32'hAAAAFFFF) begin
      bad++;
      $display("FAIL single_data: got DA=%h DB=%h, required AAAA FFFF", DA, DB);
    end
    total++;
    if (dv_cycles != 1) begin
      bad++;
      $display("FAIL single_dvalid_len: got %0d cycles, required 1", dv_cycles);
    end
    total++;
    if (sclk_cnt != 18) begin
      bad++;
      $display("FAIL single_sclk_pulses: got %0d, required 18", sclk_cnt);
    end
    total++;
    if (SCNT !== 16'd1 || sb.size() != 0) begin
      bad++;
      $display("FAIL single_scnt: got SCNT=%0d pending=%0d, required 1 and 0", SCNT, sb.size());
    end
  endtask

  task automatic test_period();
    do_reset();
    step(1); EN = 1'b1;
    for (int i = 0; i < 1300 && falls.size() < 10; i++) step(1);
    EN = 1'b0;
    total++;
    if (falls.size() != 10) begin
      bad++;
      $display("FAIL period_starts: got %0d ADCLK falls, required 10", falls.size());
    end else begin
      for (int i = 1; i < 10; i++) begin
        total++;
        if (falls[i] - falls[i-1] != PER) begin
          bad++;
          $display("FAIL period_spacing[%0d]: got %0d cycles, required %0d", i, falls[i] - falls[i-1], PER);
        end
      end
    end
    step(150);
    total++;
    if (SCNT !== 16'd10 || sb.size() != 0 || falls.size() != 10) begin
      bad++;
      $display("FAIL period_end: got SCNT=%0d pending=%0d falls=%0d, required 10 0 10",
               SCNT, sb.size(), falls.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    DREADY = 1'b0;
    next_w0 = {16'h1234, 2'b11};
    next_w1 = 18'h0;
    pulse_en();
    step(PER + 10);
    next_w0 = {16'h5678, 2'b00};
    pulse_en();
    step(PER + 10);
    total++;
    if (DA !== 16'h1234 || DVALID !== 1'b1 || OVF !== 1'b1 || SCNT !== 16'd2) begin
      bad++;
      $display("FAIL ovf_drop: got DA=%h DVALID=%b OVF=%b SCNT=%0d, required 1234 1 1 2",
               DA, DVALID, OVF, SCNT);
    end
    void'(sb.pop_back());
    step(1); CLR = 1'b1;
    step(1); CLR = 1'b0;
    total++;
    if (OVF !== 1'b0 || SCNT !== 16'd0 || DA !== 16'h1234 || DVALID !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clr: got OVF=%b SCNT=%0d DA=%h DVALID=%b, required 0 0 1234 1",
               OVF, SCNT, DA, DVALID);
    end
    DREADY = 1'b1;
    step(3);
    total++;
    if (DVALID !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL ovf_drain: got DVALID=%b pending=%0d, required 0 0", DVALID, sb.size());
    end
  endtask

  task automatic test_timeout();
    int err_cyc;
    do_reset();
    busy_stuck = 1'b1;
    step(1); EN = 1'b1;
    err_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (ERR === 1'b1) begin err_cyc = cyc; break; end
    end
    total++;
    if (err_cyc < 0 || falls.size() < 1) begin
      bad++;
      $display("FAIL timeout_err: got ERR=%b, required 1 within 200 cycles", ERR);
    end else if (err_cyc - falls[0] != 66) begin
      bad++;
      $display("FAIL timeout_err: got ERR %0d cycles after ADCLK fall, required 66", err_cyc - falls[0]);
    end
    for (int i = 0; i < 200 && falls.size() < 2; i++) step(1);
    EN = 1'b0;
    total++;
    if (falls.size() != 2 || falls[1] - falls[0] != PER) begin
      bad++;
      $display("FAIL timeout_next_start: got falls=%0d, required second fall %0d cycles after first",
               falls.size(), PER);
    end
    total++;
    if (sclk_cnt != 0 || dv_cycles != 0 || SCNT !== 16'd0) begin
      bad++;
      $display("FAIL timeout_no_shift: got sclk=%0d dvalid_cycles=%0d SCNT=%0d, required 0 0 0",
               sclk_cnt, dv_cycles, SCNT);
    end
    step(150);
    sb.delete();
    busy_stuck = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    step(1); EN = 1'b1;
    for (int i = 0; i < 200 && sclk_cnt < 9; i++) @(negedge CLK);
    total++;
    if (sclk_cnt != 9 || SCLK !== 1'b1) begin
      bad++;
      $display("FAIL rst_shift_reach: got sclk=%0d SCLK=%b, required 9 1", sclk_cnt, SCLK);
    end
    RST = 1'b1;
    #1;
    total++;
    if ({SCLK, ADCLK, DVALID} !== 3'b010) begin
      bad++;
      $display("FAIL rst_shift_async: got SCLK,ADCLK,DVALID=%b, required 010", {SCLK, ADCLK, DVALID});
    end
    sb.delete(); falls.delete();
    sclk_cnt = 0; dv_cycles = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (ADCLK !== 1'b0) begin
      bad++;
      $display("FAIL rst_shift_restart: got ADCLK=%b, required 0", ADCLK);
    end
    step(30);
    total++;
    if (dv_cycles != 0) begin
      bad++;
      $display("FAIL rst_shift_discard: got %0d DVALID cycles, required 0", dv_cycles);
    end
    EN = 1'b0;
    step(150);
    total++;
    if (dv_cycles != 1 || sb.size() != 0 || SCNT !== 16'd1) begin
      bad++;
      $display("FAIL rst_shift_new: got dvalid_cycles=%0d pending=%0d SCNT=%0d, required 1 0 1",
               dv_cycles, sb.size(), SCNT);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    step(1); EN = 1'b1;
    for (int i = 0; i < 200 && sclk_cnt < 1; i++) step(1);
    EN = 1'b0;
    step(300);
    total++;
    if (dv_cycles != 1 || sb.size() != 0 || SCNT !== 16'd1) begin
      bad++;
      $display("FAIL en_drop_deliver: got dvalid_cycles=%0d pending=%0d SCNT=%0d, required 1 0 1",
               dv_cycles, sb.size(), SCNT);
    end
    total++;
    if (falls.size() != 1 || ADCLK !== 1'b1) begin
      bad++;
      $display("FAIL en_drop_idle: got falls=%0d ADCLK=%b, required 1 1", falls.size(), ADCLK);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_period();
    test_overflow();
    test_timeout();
    test_reset_mid_shift();
    test_en_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
ADC_SERIAL_READER -- requirements
Module: adc_serial_reader

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 1, CLK cycles per SCLK half-period (>=1).
REQ-002 SHALL have parameter PERIOD, default 100, CLK cycles between successive ADCLK falling edges (>=64).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 64, max CLK cycles spent in WAITB.
REQ-004 SHALL have port CLK  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports EN  in  1  run enable, level; CLR  in  1  synchronous clear of OVF/ERR/SCNT.
REQ-007 SHALL have ports BUSYAD0, BUSYAD1  in  1  AD7643 busy; SDOUT0, SDOUT1  in  1  serial data, MSB first.
REQ-008 SHALL have ports ADCLK  out  1  conversion start, active-low; SCLK  out  1  shared serial clock; CS  out  1  chip select, constant 0.
REQ-009 SHALL have ports DA, DB  out  16  channel 0/1 sample; DVALID  out  1; DREADY  in  1  consumer accept.
REQ-010 SHALL have ports OVF  out  1  sticky drop flag; ERR  out  1  sticky busy timeout; SCNT  out  16  completed-conversion count.

Function
REQ-011 SHALL implement states IDLE, CONV, WAITB, SHIFT, STORE, HOLD.
REQ-012 IDLE: SHALL go to CONV on the first edge EN=1; ADCLK low in the following cycle.
REQ-013 CONV: SHALL drive ADCLK=0 for exactly 2 cycles, then WAITB; PERIOD counter restarts at 0 on CONV entry.
REQ-014 WAITB: SHALL wait until either BUSY seen high, then both BUSY low, then SHIFT.
REQ-015 WAITB: if BUSY_TIMEOUT cycles elapse first, SHALL set ERR, skip SHIFT/STORE, go HOLD; SCNT unchanged.
REQ-016 SHIFT: SHALL emit 18 SCLK pulses, each low SCLK_DIV cycles then high SCLK_DIV cycles; SCLK=0 on exit.
REQ-017 SHIFT: SHALL sample SDOUT0/SDOUT1 into 18-bit shift registers at each 0->1 SCLK transition, MSB first.
REQ-018 STORE (1 cycle): sample = shift[17:2] (18-bit truncated to 16); SCNT increments, wraps 0xFFFF->0x0000.
REQ-019 STORE: if DVALID=0, or DVALID=1 and DREADY=1 in same cycle, SHALL load DA/DB and set DVALID=1, no OVF.
REQ-020 STORE: if DVALID=1 and DREADY=0, SHALL drop the new sample, keep DA/DB, set OVF.
REQ-021 Handshake: DVALID&DREADY at an edge SHALL be a transfer; DVALID clears unless REQ-019 reload; DA/DB stable while DVALID=1.
REQ-022 HOLD: SHALL wait until PERIOD counter = PERIOD-1, then CONV if EN=1 else IDLE.
REQ-023 EN deassert mid-cycle SHALL NOT abort; current conversion completes, then IDLE.
REQ-024 CLR SHALL zero OVF, ERR, SCNT; CLR wins over simultaneous set/increment.
REQ-025 ADCLK SHALL idle 1, SCLK idle 0, outside CONV/SHIFT respectively.

Reset
REQ-026 RST=1 SHALL immediately force: state IDLE, ADCLK=1, SCLK=0, CS=0, DA=DB=0, DVALID=0, OVF=0, ERR=0, SCNT=0, shift registers and counters 0.
REQ-027 RST asserted mid-SHIFT/STORE SHALL discard the partial sample; no DVALID after release until a new full conversion.

Verification
REQ-028 SDOUT0 bits 18'h2AAAA, SDOUT1 held 1, DREADY=1 -> DA=0xAAAA, DB=0xFFFF, DVALID one cycle, SCNT=1.
REQ-029 PERIOD=100, EN held 1, DREADY=1, 10 conversions -> ADCLK falling edges exactly 100 cycles apart, SCNT=10.
REQ-030 DREADY=0, two conversions (first 0x1234, second 0x5678) -> DA=0x1234 held, OVF=1, SCNT=2; then CLR -> OVF=0, SCNT=0, DA unchanged.
REQ-031 BUSYAD0/1 stuck 0 -> ERR=1 after 64 WAITB cycles, no SCLK pulses, DVALID=0, next ADCLK still at PERIOD.
REQ-032 RST pulse during 9th SCLK pulse -> SCLK=0, ADCLK=1, DVALID=0 same cycle; after release with EN=1, ADCLK low 1 cycle later.
REQ-033 EN dropped during SHIFT -> sample delivered (DVALID=1), then IDLE, no further ADCLK pulses.
